// File: rtl/line_window_feeder_pkg.sv
// Shared types and constants for the 5-row line window feeder.
// Four line banks feed the five-tap vertical FIR alongside the live pixel.
package line_window_feeder_pkg;

    localparam int unsigned PIXEL_W    = 8;
    localparam int unsigned FIR_TAPS   = 5;
    localparam int unsigned LINE_BANKS = FIR_TAPS - 1;

    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef logic [1:0]         bank_t;

    // Circular bank index arithmetic; the 2-bit width wraps mod 4.
    function automatic bank_t bank_add(bank_t b, int unsigned k);
        return b + bank_t'(k);
    endfunction

endpackage

// File: rtl/line_window_feeder_if.sv
// Pixel stream in, 5-pixel vertical column out.
// The master drives the raster stream; the slave is the feeder itself.
interface line_window_feeder_if;
    import line_window_feeder_pkg::*;

    logic   in_valid;
    logic   in_sof;
    pixel_t in_pixel;
    pixel_t pixel0;
    pixel_t pixel1;
    pixel_t pixel2;
    pixel_t pixel3;
    pixel_t pixel4;
    logic   out_valid;
    logic   frame_done;

    modport master (
        output in_valid, in_sof, in_pixel,
        input  pixel0, pixel1, pixel2, pixel3, pixel4, out_valid, frame_done
    );

    modport slave (
        input  in_valid, in_sof, in_pixel,
        output pixel0, pixel1, pixel2, pixel3, pixel4, out_valid, frame_done
    );

endinterface

// File: rtl/line_window_feeder_line_ram.sv
// Single-port line buffer, synchronous read-before-write, BRAM-inferable.
// Read and write enables are separate so the read register can hold its value.
module line_ram
    import line_window_feeder_pkg::*;
#(
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  pixel_t            wdata,
    output pixel_t            rdata
);

    pixel_t mem [DEPTH];
    pixel_t rdata_q;

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rdata_q <= mem[addr];
        end
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_window_feeder.sv
// Buffers the previous four lines of a raster stream and emits one vertical
// 5-pixel column per accepted pixel once four full lines are available.
module line_window_feeder
    import line_window_feeder_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 64,
    parameter int unsigned IMG_HEIGHT = 64,
    parameter int unsigned COL_W      = 6,
    parameter int unsigned ROW_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    line_window_feeder_if.slave  bus
);

    logic [COL_W-1:0] col_q, col_d, col_eff;
    logic [ROW_W-1:0] row_q, row_d, row_eff;
    bank_t            wr_bank_q, wr_bank_d, bank_eff;

    bank_t            sel_q;
    pixel_t           pix4_q;
    logic             primed_q;
    logic             out_valid_q;
    logic             frame_done_q;

    logic             sof;
    logic             last_col;
    logic             last_pix;
    logic             emit;
    pixel_t           rd_data [LINE_BANKS];

    // A start-of-frame pixel overrides whatever position the counters hold.
    always_comb begin
        sof      = bus.in_valid && bus.in_sof;
        col_eff  = sof ? '0 : col_q;
        row_eff  = sof ? '0 : row_q;
        bank_eff = sof ? '0 : wr_bank_q;

        last_col = (col_eff == COL_W'(IMG_WIDTH - 1));
        last_pix = last_col && (row_eff == ROW_W'(IMG_HEIGHT - 1));
        emit     = bus.in_valid && (row_eff >= ROW_W'(LINE_BANKS));

        col_d     = col_q;
        row_d     = row_q;
        wr_bank_d = wr_bank_q;
        if (bus.in_valid) begin
            if (last_pix) begin
                col_d     = '0;
                row_d     = '0;
                wr_bank_d = '0;
            end else if (last_col) begin
                col_d     = '0;
                row_d     = row_eff + 1'b1;
                wr_bank_d = bank_add(bank_eff, 1);
            end else begin
                col_d     = col_eff + 1'b1;
                row_d     = row_eff;
                wr_bank_d = bank_eff;
            end
        end
    end

    // The bank being overwritten still holds row r-4 on its read port.
    for (genvar b = 0; b < LINE_BANKS; b++) begin : g_bank
        line_ram #(
            .DEPTH  (IMG_WIDTH),
            .ADDR_W (COL_W)
        ) u_line_ram (
            .clk   (clk),
            .rd_en (emit),
            .we    (bus.in_valid && (bank_eff == bank_t'(b))),
            .addr  (col_eff),
            .wdata (bus.in_pixel),
            .rdata (rd_data[b])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q        <= '0;
            row_q        <= '0;
            wr_bank_q    <= '0;
            sel_q        <= '0;
            pix4_q       <= '0;
            primed_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            wr_bank_q    <= wr_bank_d;
            out_valid_q  <= emit;
            frame_done_q <= bus.in_valid && last_pix;
            if (emit) begin
                sel_q    <= bank_eff;
                pix4_q   <= bus.in_pixel;
                primed_q <= 1'b1;
            end
        end
    end

    // RAM read registers have no reset; primed_q masks them until the first column.
    assign bus.pixel0     = primed_q ? rd_data[sel_q]              : '0;
    assign bus.pixel1     = primed_q ? rd_data[bank_add(sel_q, 1)] : '0;
    assign bus.pixel2     = primed_q ? rd_data[bank_add(sel_q, 2)] : '0;
    assign bus.pixel3     = primed_q ? rd_data[bank_add(sel_q, 3)] : '0;
    assign bus.pixel4     = pix4_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_line_window_feeder.sv
// Self-checking bench for line_window_feeder on an 8x6 image, using a frame-image
// reference model that derives each expected column from the accepted pixels.
module tb_line_window_feeder;

    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    line_window_feeder_if bus ();

    line_window_feeder #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .COL_W      (3),
        .ROW_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: the image of the frame in progress.
    logic [7:0]  img [H][W];
    int          pos;
    logic        exp_valid;
    logic        exp_done;
    logic [39:0] exp_vec;
    logic [39:0] golden_q [$];

    wire [39:0] got_vec = {bus.pixel0, bus.pixel1, bus.pixel2, bus.pixel3, bus.pixel4};

    task automatic model_reset();
        pos       = 0;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        exp_vec   = '0;
    endtask

    // Drive one cycle, advance the model, and return at posedge+1.
    task automatic step(input logic v, input logic s, input logic [7:0] p);
        int r;
        int c;
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_pixel = p;
        @(posedge clk);
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (v) begin
            if (s) pos = 0;
            r = pos / W;
            c = pos % W;
            img[r][c] = p;
            if (r >= 4) begin
                exp_valid = 1'b1;
                exp_vec   = {img[r-4][c], img[r-3][c], img[r-2][c], img[r-1][c], img[r][c]};
            end
            pos++;
            if (pos == W * H) begin
                pos      = 0;
                exp_done = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_pixel = '0;
        model_reset();
        #22;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || got_vec !== 40'h0) begin
            n_fail++;
            $display("FAIL reset: valid=%b done=%b col=%h, want 0 0 0",
                     bus.out_valid, bus.frame_done, got_vec);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        // in_sof without in_valid must not disturb anything.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'($urandom));
            n_chk++;
            if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL idle_sof: valid=%b done=%b col=%h, want %b %b %h",
                         bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
            end
        end
    endtask

    task automatic test_continuous();
        int nvalid = 0;
        int ndone  = 0;
        logic [39:0] first = '0;
        logic [39:0] last  = '0;
        golden_q.delete();
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                n_chk++;
                if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL continuous r%0d c%0d: valid=%b done=%b col=%h, want %b %b %h",
                             r, c, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                end
                if (exp_valid) golden_q.push_back(exp_vec);
                if (bus.out_valid === 1'b1) begin
                    if (nvalid == 0) first = got_vec;
                    last = got_vec;
                    nvalid++;
                end
                if (bus.frame_done === 1'b1) ndone++;
            end
        end
        n_chk++;
        if (nvalid != 16) begin
            n_fail++;
            $display("FAIL continuous_count: got %0d valid columns, want 16", nvalid);
        end
        n_chk++;
        if (first !== 40'h0010203040) begin
            n_fail++;
            $display("FAIL continuous_first: got %h, want 0010203040", first);
        end
        n_chk++;
        if (last !== 40'h1727374757) begin
            n_fail++;
            $display("FAIL continuous_last: got %h, want 1727374757", last);
        end
        n_chk++;
        if (ndone != 1) begin
            n_fail++;
            $display("FAIL continuous_done: got %0d pulses, want 1", ndone);
        end
    endtask

    // Runs immediately after test_continuous with no idle cycle between frames.
    task automatic test_back_to_back();
        int nvalid = 0;
        int ndone  = 0;
        logic [39:0] first = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 1'b0, 8'(r * 16 + c + 1));
                n_chk++;
                if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL back_to_back r%0d c%0d: valid=%b done=%b col=%h, want %b %b %h",
                             r, c, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                end
                if (bus.out_valid === 1'b1) begin
                    if (nvalid == 0) first = got_vec;
                    nvalid++;
                end
                if (bus.frame_done === 1'b1) ndone++;
            end
        end
        step(1'b0, 1'b0, 8'h00);
        n_chk++;
        if (bus.frame_done !== 1'b0 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse_width: valid=%b done=%b, want 0 0", bus.out_valid, bus.frame_done);
        end
        n_chk++;
        if (first !== 40'h0111213141 || nvalid != 16 || ndone != 1) begin
            n_fail++;
            $display("FAIL back_to_back_summary: first=%h n=%0d done=%0d, want 0111213141 16 1",
                     first, nvalid, ndone);
        end
    endtask

    task automatic test_gaps();
        int k = 0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                while ($urandom_range(0, 99) < 30) begin
                    step(1'b0, 1'b0, 8'($urandom));
                    n_chk++;
                    if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                        n_fail++;
                        $display("FAIL gaps_idle: valid=%b done=%b col=%h, want %b %b %h",
                                 bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                    end
                end
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                n_chk++;
                if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL gaps r%0d c%0d: valid=%b done=%b col=%h, want %b %b %h",
                             r, c, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                end
                if (bus.out_valid === 1'b1) begin
                    n_chk++;
                    if (k >= golden_q.size() || got_vec !== golden_q[k]) begin
                        n_fail++;
                        $display("FAIL gaps_vs_continuous #%0d: got %h", k, got_vec);
                    end
                    k++;
                end
            end
        end
        n_chk++;
        if (k != 16) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d valid columns, want 16", k);
        end
    endtask

    task automatic test_sof_abort();
        int ndone  = 0;
        int nvalid = 0;
        logic [39:0] first = '0;
        // Partial frame of distinctive data, abandoned at (3,2).
        for (int p = 0; p < 3 * W + 2; p++) begin
            step(1'b1, (p == 0), 8'(8'hA0 + 8'($urandom_range(0, 15))));
            n_chk++;
            if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL sof_partial: valid=%b done=%b col=%h, want %b %b %h",
                         bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
            end
            if (bus.frame_done === 1'b1) ndone++;
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                n_chk++;
                if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL sof_new r%0d c%0d: valid=%b done=%b col=%h, want %b %b %h",
                             r, c, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                end
                if (bus.out_valid === 1'b1) begin
                    if (nvalid == 0) first = got_vec;
                    nvalid++;
                end
                if (bus.frame_done === 1'b1 && !(r == H - 1 && c == W - 1)) ndone++;
            end
        end
        n_chk++;
        if (ndone != 0 || first !== 40'h0010203040 || nvalid != 16) begin
            n_fail++;
            $display("FAIL sof_abort_summary: stray_done=%0d first=%h n=%0d, want 0 0010203040 16",
                     ndone, first, nvalid);
        end
    endtask

    task automatic test_async_reset();
        int k = 0;
        for (int p = 0; p < 4 * W + 4; p++) begin
            step(1'b1, (p == 0), 8'((p / W) * 16 + p % W));
            n_chk++;
            if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL pre_reset: valid=%b done=%b col=%h, want %b %b %h",
                         bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
            end
        end
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || got_vec !== 40'h0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b done=%b col=%h, want 0 0 0",
                     bus.out_valid, bus.frame_done, got_vec);
        end
        #3 rst = 1'b1;
        model_reset();
        // Restart from the cleared counters, without in_sof.
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                step(1'b1, 1'b0, 8'(r * 16 + c));
                n_chk++;
                if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL post_reset r%0d c%0d: valid=%b done=%b col=%h, want %b %b %h",
                             r, c, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                end
                if (bus.out_valid === 1'b1) begin
                    n_chk++;
                    if (k >= golden_q.size() || got_vec !== golden_q[k]) begin
                        n_fail++;
                        $display("FAIL post_reset_vs_continuous #%0d: got %h", k, got_vec);
                    end
                    k++;
                end
            end
        end
        n_chk++;
        if (k != 16) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d valid columns, want 16", k);
        end
    endtask

    task automatic test_rotation();
        int nvalid = 0;
        for (int f = 0; f < 2; f++) begin
            for (int p = 0; p < W * H; p++) begin
                while ($urandom_range(0, 99) < 20) begin
                    step(1'b0, 1'b0, 8'($urandom));
                    n_chk++;
                    if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                        n_fail++;
                        $display("FAIL rotation_idle f%0d: valid=%b done=%b col=%h, want %b %b %h",
                                 f, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                    end
                end
                step(1'b1, (f == 0 && p == 0), 8'($urandom));
                n_chk++;
                if (bus.out_valid !== exp_valid || bus.frame_done !== exp_done || got_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL rotation f%0d p%0d: valid=%b done=%b col=%h, want %b %b %h",
                             f, p, bus.out_valid, bus.frame_done, got_vec, exp_valid, exp_done, exp_vec);
                end
                if (bus.out_valid === 1'b1) nvalid++;
            end
        end
        n_chk++;
        if (nvalid != 32) begin
            n_fail++;
            $display("FAIL rotation_count: got %0d valid columns, want 32", nvalid);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_back_to_back();
        test_gaps();
        test_sof_abort();
        test_async_reset();
        test_rotation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
